// File: rtl/addsub_mul_sequencer.sv
// addsub_mul_sequencer: shift-and-add multiplier controller that time-shares one external add/sub unit
// for operand absolute values, WIDTH add/shift iterations and the final 64-bit negation.
module addsub_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             add_sna_o,
  input  logic [WIDTH-1:0] add_y_i,
  input  logic             add_co_i
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_NEG_LO, S_NEG_HI, S_DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q, prod_hi_q, prod_lo_q;
  logic [CW-1:0] cnt_q;
  logic sgn_q, neg_q, c_q;
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;
  assign prod_hi_o = prod_hi_q;
  assign prod_lo_o = prod_lo_q;
  always_comb begin
    state_d = state_q;
    add_a_o = '0;
    add_b_o = '0;
    add_sna_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_ABS_A;
      S_ABS_A: begin
        add_b_o = mcand_q;
        add_sna_o = 1'b1;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        add_b_o = lo_q;
        add_sna_o = 1'b1;
        state_d = S_ITER;
      end
      S_ITER: begin
        add_a_o = hi_q;
        add_b_o = lo_q[0] ? mcand_q : '0;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_NEG_LO;
      end
      S_NEG_LO: begin
        add_b_o = lo_q;
        add_sna_o = 1'b1;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        // ~hi + c: subtracting from all-ones gives plain ~hi when no carry came out of the low word
        add_a_o = c_q ? '0 : '1;
        add_b_o = hi_q;
        add_sna_o = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (start_i) begin
          mcand_q <= op_a_i;
          lo_q <= op_b_i;
          sgn_q <= signed_i;
          neg_q <= signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
        end
        S_ABS_A: if (sgn_q && mcand_q[WIDTH-1]) mcand_q <= add_y_i;
        S_ABS_B: begin
          if (sgn_q && lo_q[WIDTH-1]) lo_q <= add_y_i;
          hi_q <= '0;
          cnt_q <= '0;
        end
        S_ITER: begin
          hi_q <= {add_co_i, add_y_i[WIDTH-1:1]};
          lo_q <= {add_y_i[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        S_NEG_LO: if (neg_q) begin
          lo_q <= add_y_i;
          c_q <= add_co_i;
        end
        S_NEG_HI: begin
          // result registers load here so they are already valid while DONE is high
          if (neg_q) hi_q <= add_y_i;
          prod_hi_q <= neg_q ? add_y_i : hi_q;
          prod_lo_q <= lo_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_mul_sequencer.sv
// tb_addsub_mul_sequencer: scoreboard bench with a behavioural ripple add/sub unit beside the sequencer
module tb_addsub_mul_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, sgn, busy, done, add_sna, add_co;
  logic [31:0] op_a, op_b, prod_hi, prod_lo, add_a, add_b, add_y;
  logic [32:0] sum;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [63:0] p;
    int due;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  addsub_mul_sequencer #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done),
    .prod_hi_o(prod_hi), .prod_lo_o(prod_lo), .add_a_o(add_a), .add_b_o(add_b),
    .add_sna_o(add_sna), .add_y_i(add_y), .add_co_i(add_co)
  );
  assign sum = {1'b0, add_a} + {1'b0, add_sna ? ~add_b : add_b} + 33'(add_sna);
  assign add_y = sum[31:0];
  assign add_co = sum[32];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction
  // DONE is observed on the falling edge inside its cycle; the due count is taken there
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        chk("prod", {prod_hi, prod_lo}, mon_e.p);
        chk("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sgn = s;
    op_a = a;
    op_b = b;
    start = 1'b1;
    sb_q.push_back('{model(s, a, b), cyc + 37});
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 120 && sb_q.size() != 0; i++) @(posedge clk);
    chk("timeout", 64'(sb_q.size()), 0);
    @(negedge clk);
    #1;
    chk("done_width", done, 0);
  endtask
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b);
    issue(s, a, b);
    @(negedge clk);
    start = 1'b0;
    chk("busy", busy, 1);
    wait_empty();
  endtask
  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    sgn = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", {prod_hi, prod_lo}, 0);
    chk("rst_add", {add_a, add_b, add_sna}, 0);
    rst_n = 1'b1;
    run(1'b0, 32'd7, 32'd6);
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(1'b1, 32'hFFFFFFFD, 32'd5);
    run(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB);
    run(1'b1, 32'd0, 32'hFFFFFFF9);
    run(1'b1, 32'h80000000, 32'h80000000);
    run(1'b1, 32'h80000000, 32'd1);
    for (int i = 0; i < 6; i++) run(1'(i), $urandom, $urandom);
    // a START pulse with new operands while busy must not disturb the running product
    issue(1'b0, 32'd7, 32'd6);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op_a = 32'd123;
    op_b = 32'd456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    // START held high: ignored while busy and in DONE, taken again one IDLE cycle later
    issue(1'b1, 32'hFFFFFFFD, 32'd5);
    k = cyc;
    repeat (5) @(negedge clk);
    op_a = 32'd100;
    op_b = 32'hFFFFFFF9;
    sb_q.push_back('{model(1'b1, 32'd100, 32'hFFFFFFF9), k + 75});
    while (cyc < k + 39) @(negedge clk);
    start = 1'b0;
    wait_empty();
    // asynchronous reset in the middle of the iterations
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 13) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prod", {prod_hi, prod_lo}, 0);
    chk("abort_add", {add_a, add_b, add_sna}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 32'h80000000, 32'd1);
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (45) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
